// File: rtl/vram_arbiter.sv
// vram_arbiter: one single-port VRAM shared by video scanout (fixed priority) and the CPU bridge (aged).
// Define VRAM_ARB_STATS_EN to build the contention counter; otherwise conflict_count is tied to 0.
module vram_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 8,
  parameter int MAX_CPU_WAIT = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       conflict_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARB_VID = 2'd1, ARB_CPU = 2'd2} grant_e;

  localparam logic [7:0] WAIT_MAX = 8'(MAX_CPU_WAIT);

  grant_e            grant_d, grant_q;
  logic [7:0]        wait_ctr_d, wait_ctr_q;
  logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
  logic              mem_we_d, mem_we_q;
  logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;
  logic              vid_rd_q, cpu_rd_q;
  logic [DATA_W-1:0] vid_rdata_q, cpu_rdata_q;
  logic              vid_elig, cpu_elig;

  // The still-held request during its own ack cycle is not a new request.
  assign vid_elig = vid_req & (grant_q != ARB_VID);
  assign cpu_elig = cpu_req & (grant_q != ARB_CPU);

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q     <= IDLE;
      wait_ctr_q  <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      vid_rd_q    <= 1'b0;
      cpu_rd_q    <= 1'b0;
      vid_rdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      grant_q     <= grant_d;
      wait_ctr_q  <= wait_ctr_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      vid_rd_q    <= (grant_q == ARB_VID);
      cpu_rd_q    <= (grant_q == ARB_CPU) & ~mem_we_q;
      vid_rdata_q <= vid_rdata;
      cpu_rdata_q <= cpu_rdata;
    end
  end

  always_comb begin
    grant_d = IDLE;
    if (cpu_elig && wait_ctr_q == WAIT_MAX) grant_d = ARB_CPU;
    else if (vid_elig)                      grant_d = ARB_VID;
    else if (cpu_elig)                      grant_d = ARB_CPU;
  end

  always_comb begin
    wait_ctr_d = wait_ctr_q;
    if (!cpu_req || grant_d == ARB_CPU)          wait_ctr_d = '0;
    else if (cpu_elig && wait_ctr_q != WAIT_MAX) wait_ctr_d = wait_ctr_q + 8'd1;
  end

  // Address and write data hold on idle cycles; only a CPU write raises mem_we.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    case (grant_d)
      ARB_VID: mem_addr_d = vid_addr;
      ARB_CPU: begin
        mem_addr_d = cpu_addr;
        mem_we_d   = cpu_we;
        if (cpu_we) mem_wdata_d = cpu_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    vid_ack = 1'b0;
    cpu_ack = 1'b0;
    case (grant_q)
      ARB_VID: vid_ack = 1'b1;
      ARB_CPU: cpu_ack = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

  // Gating with reset kills a read already in flight when reset arrives.
  assign vid_rvalid = vid_rd_q & ~reset;
  assign cpu_rvalid = cpu_rd_q & ~reset;
  assign vid_rdata  = vid_rvalid ? mem_rdata : vid_rdata_q;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] conflict_d, conflict_q;

  always_comb begin
    conflict_d = conflict_q;
    if (vid_elig && cpu_elig && conflict_q != 16'hFFFF) conflict_d = conflict_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) conflict_q <= '0;
    else       conflict_q <= conflict_d;
  end

  assign conflict_count = conflict_q;
`else
  assign conflict_count = '0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_vram_arbiter;
  localparam int MAXW = 7;
`ifdef VRAM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        vid_req, cpu_req, cpu_we;
  logic [12:0] vid_addr, cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        vid_ack, vid_rvalid, cpu_ack, cpu_rvalid, mem_we;
  logic [7:0]  vid_rdata, cpu_rdata, mem_wdata, mem_rdata;
  logic [12:0] mem_addr;
  logic [15:0] conflict_count;

  int vectors = 0;
  int miscompares = 0;

  vram_arbiter #(.ADDR_W(13), .DATA_W(8), .MAX_CPU_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input logic [12:0] a);
    logic [15:0] t;
    t = 16'(a) * 16'd7 + 16'd3;
    return t[7:0];
  endfunction

  // Synchronous single-port RAM, one-cycle read latency, preloaded with pat().
  logic [7:0] ram [0:8191];
  logic       ram_init;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 8192; i++) ram[i] <= pat(13'(i));
    end else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_vack"}, 32'(vid_ack), 0);
    chk({p, "_cack"}, 32'(cpu_ack), 0);
    chk({p, "_vrv"}, 32'(vid_rvalid), 0);
    chk({p, "_crv"}, 32'(cpu_rvalid), 0);
    chk({p, "_addr"}, 32'(mem_addr), 0);
    chk({p, "_we"}, 32'(mem_we), 0);
    chk({p, "_wd"}, 32'(mem_wdata), 0);
    chk({p, "_vrd"}, 32'(vid_rdata), 0);
    chk({p, "_crd"}, 32'(cpu_rdata), 0);
    chk({p, "_cnt"}, 32'(conflict_count), 0);
  endtask

  task automatic do_reset;
    vid_req = 0; cpu_req = 0; cpu_we = 0;
    vid_addr = 0; cpu_addr = 0; cpu_wdata = 0;
    reset = 1;
    tick; tick;
    reset = 0;
  endtask

  typedef struct {
    logic vreq; logic [12:0] va; logic creq; logic cwe; logic [12:0] ca; logic [7:0] cwd;
    logic evack; logic ecack; logic ewe; logic [12:0] eaddr; logic [7:0] ewd;
    logic evrv; logic ecrv; logic [7:0] evrd; logic [7:0] ecrd;
  } vec_t;

  function automatic vec_t mk(input logic vreq, input logic [12:0] va, input logic creq,
                              input logic cwe, input logic [12:0] ca, input logic [7:0] cwd,
                              input logic evack, input logic ecack, input logic ewe,
                              input logic [12:0] eaddr, input logic [7:0] ewd,
                              input logic evrv, input logic ecrv,
                              input logic [7:0] evrd, input logic [7:0] ecrd);
    vec_t v;
    v.vreq = vreq; v.va = va; v.creq = creq; v.cwe = cwe; v.ca = ca; v.cwd = cwd;
    v.evack = evack; v.ecack = ecack; v.ewe = ewe; v.eaddr = eaddr; v.ewd = ewd;
    v.evrv = evrv; v.ecrv = ecrv; v.evrd = evrd; v.ecrd = ecrd;
    return v;
  endfunction

  // Reference model state: what each output should show in the current cycle.
  logic        m_vack, m_cack, m_we, m_vrv, m_crv;
  logic [12:0] m_addr;
  logic [7:0]  m_wd, m_vrd, m_crd, m_iss;
  int          m_wait, m_cnt, cstart, win;
  logic [7:0]  sh [0:8191];

  initial begin
    vec_t tbl [11];
    logic [7:0] p10, p200;
    int lat;
    bit got, ve, ce;

    // ---- reset with both requesters asserted
    reset = 1; ram_init = 1;
    vid_req = 1; vid_addr = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 13'h040; cpu_wdata = 0;
    tick;
    ram_init = 0;
    tick; tick;
    chk_zero("rst");
    reset = 0;
    tick;
    chk("rst_first_vack", 32'(vid_ack), 1);
    chk("rst_first_cack", 32'(cpu_ack), 0);
    chk("rst_first_addr", 32'(mem_addr), 0);
    tick;
    chk("rst_then_cack", 32'(cpu_ack), 1);
    chk("rst_then_vack", 32'(vid_ack), 0);
    chk("rst_then_addr", 32'(mem_addr), 32'h040);
    chk("rst_vrv", 32'(vid_rvalid), 1);
    chk("rst_vrd", 32'(vid_rdata), 32'(pat(13'h000)));
    vid_req = 0; cpu_req = 0;
    tick;
    chk("rst_crv", 32'(cpu_rvalid), 1);
    chk("rst_crd", 32'(cpu_rdata), 32'(pat(13'h040)));
    chk("rst_idle_vack", 32'(vid_ack), 0);

    // ---- directed vector table
    p10 = pat(13'h010); p200 = pat(13'h200);
    tbl[0]  = mk(0, 0,      1, 1, 13'h123, 8'hA5, 0, 0, 0, 13'h000, 0,     0, 0, 0,   0);
    tbl[1]  = mk(0, 0,      1, 1, 13'h123, 8'hA5, 0, 1, 1, 13'h123, 8'hA5, 0, 0, 0,   0);
    tbl[2]  = mk(0, 0,      1, 0, 13'h123, 0,     0, 0, 0, 13'h123, 0,     0, 0, 0,   0);
    tbl[3]  = mk(0, 0,      1, 0, 13'h123, 0,     0, 1, 0, 13'h123, 0,     0, 0, 0,   0);
    tbl[4]  = mk(0, 0,      0, 0, 0,       0,     0, 0, 0, 13'h123, 0,     0, 1, 0,   8'hA5);
    tbl[5]  = mk(1, 13'h10, 1, 0, 13'h200, 0,     0, 0, 0, 13'h123, 0,     0, 0, 0,   8'hA5);
    tbl[6]  = mk(1, 13'h10, 1, 0, 13'h200, 0,     1, 0, 0, 13'h010, 0,     0, 0, 0,   8'hA5);
    tbl[7]  = mk(1, 13'h10, 1, 0, 13'h200, 0,     0, 1, 0, 13'h200, 0,     1, 0, p10, 8'hA5);
    tbl[8]  = mk(0, 0,      0, 0, 0,       0,     1, 0, 0, 13'h010, 0,     0, 1, p10, p200);
    tbl[9]  = mk(0, 0,      0, 0, 0,       0,     0, 0, 0, 13'h010, 0,     1, 0, p10, p200);
    tbl[10] = mk(0, 0,      0, 0, 0,       0,     0, 0, 0, 13'h010, 0,     0, 0, p10, p200);
    do_reset;
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("tbl%0d_vack", i), 32'(vid_ack), 32'(tbl[i].evack));
      chk($sformatf("tbl%0d_cack", i), 32'(cpu_ack), 32'(tbl[i].ecack));
      chk($sformatf("tbl%0d_we", i), 32'(mem_we), 32'(tbl[i].ewe));
      chk($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(tbl[i].eaddr));
      if (tbl[i].ewe) chk($sformatf("tbl%0d_wd", i), 32'(mem_wdata), 32'(tbl[i].ewd));
      chk($sformatf("tbl%0d_vrv", i), 32'(vid_rvalid), 32'(tbl[i].evrv));
      chk($sformatf("tbl%0d_crv", i), 32'(cpu_rvalid), 32'(tbl[i].ecrv));
      chk($sformatf("tbl%0d_vrd", i), 32'(vid_rdata), 32'(tbl[i].evrd));
      chk($sformatf("tbl%0d_crd", i), 32'(cpu_rdata), 32'(tbl[i].ecrd));
      vid_req = tbl[i].vreq; vid_addr = tbl[i].va;
      cpu_req = tbl[i].creq; cpu_we = tbl[i].cwe; cpu_addr = tbl[i].ca; cpu_wdata = tbl[i].cwd;
      tick;
    end
    chk("tbl_conflicts", 32'(conflict_count), STATS ? 1 : 0);

    // ---- video streaming, CPU idle
    do_reset;
    vid_req = 1; vid_addr = 0;
    for (int c = 0; c <= 16; c++) begin
      chk($sformatf("strm%0d_vack", c), 32'(vid_ack), 32'(c % 2 == 1));
      if (c % 2 == 1) chk($sformatf("strm%0d_addr", c), 32'(mem_addr), 32'(c / 2));
      chk($sformatf("strm%0d_vrv", c), 32'(vid_rvalid), 32'(c >= 2 && c % 2 == 0));
      if (c >= 2 && c % 2 == 0)
        chk($sformatf("strm%0d_vrd", c), 32'(vid_rdata), 32'(pat(13'((c - 2) / 2))));
      if (vid_ack) vid_addr = vid_addr + 13'd1;
      tick;
    end

    // ---- CPU read against continuous video traffic
    if (vid_ack) vid_addr = vid_addr + 13'd1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 13'h040;
    got = 0; lat = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      tick;
      if (vid_ack) vid_addr = vid_addr + 13'd1;
      if (cpu_ack) begin
        got = 1; lat = c;
        chk("starve_wait_clr", 32'(dut.wait_ctr_q), 0);
        cpu_req = 0;
      end
    end
    chk("starve_lat_ok", 32'(got && lat <= MAXW + 2), 1);
    tick;
    chk("starve_crv", 32'(cpu_rvalid), 32'(got));
    chk("starve_crd", 32'(cpu_rdata), 32'(pat(13'h040)));

    // ---- reset while a video read is in flight
    got = 0;
    for (int c = 0; c < 4 && !got; c++) begin
      if (vid_ack) got = 1;
      else tick;
    end
    chk("midrd_saw_vack", 32'(got), 1);
    tick;
    reset = 1;
    #1;
    chk("midrd_no_vrv", 32'(vid_rvalid), 0);
    vid_req = 0; cpu_req = 0;
    tick;
    chk_zero("midrd");
    reset = 0;

    // ---- five episodes of one simultaneous-eligibility cycle each
    do_reset;
    for (int e = 0; e < 5; e++) begin
      vid_req = 1; vid_addr = 13'(e); cpu_req = 1; cpu_we = 0; cpu_addr = 13'(32 + e);
      tick; tick;
      vid_req = 0; cpu_req = 0;
      tick; tick;
    end
    chk("stats_count", 32'(conflict_count), STATS ? 5 : 0);

    // ---- randomized traffic against the reference model
    do_reset;
    for (int i = 0; i < 8192; i++) sh[i] = pat(13'(i));
    m_vack = 0; m_cack = 0; m_we = 0; m_vrv = 0; m_crv = 0;
    m_addr = 0; m_wd = 0; m_vrd = 0; m_crd = 0; m_iss = 0;
    m_wait = 0; m_cnt = 0; cstart = 0;
    for (int k = 0; k < 3000; k++) begin
      chk("rnd_vack", 32'(vid_ack), 32'(m_vack));
      chk("rnd_cack", 32'(cpu_ack), 32'(m_cack));
      chk("rnd_we", 32'(mem_we), 32'(m_we));
      chk("rnd_addr", 32'(mem_addr), 32'(m_addr));
      if (m_we) chk("rnd_wd", 32'(mem_wdata), 32'(m_wd));
      chk("rnd_vrv", 32'(vid_rvalid), 32'(m_vrv));
      chk("rnd_crv", 32'(cpu_rvalid), 32'(m_crv));
      chk("rnd_vrd", 32'(vid_rdata), 32'(m_vrd));
      chk("rnd_crd", 32'(cpu_rdata), 32'(m_crd));
      chk("rnd_cnt", 32'(conflict_count), STATS ? 32'(m_cnt) : 0);
      if (cpu_req && cpu_ack) chk("rnd_cpu_lat", 32'(k - cstart <= MAXW + 2), 1);

      if (!vid_req || m_vack) begin
        vid_req  = ($urandom_range(0, 3) != 0);
        vid_addr = 13'($urandom_range(0, 255));
      end
      if (!cpu_req || m_cack) begin
        cpu_req   = ($urandom_range(0, 1) != 0);
        cpu_we    = ($urandom_range(0, 1) != 0);
        cpu_addr  = 13'($urandom_range(0, 255));
        cpu_wdata = 8'($urandom_range(0, 255));
        cstart    = k;
      end

      // Decide this cycle's winner from the rules, then advance one cycle.
      ve = vid_req && !m_vack;
      ce = cpu_req && !m_cack;
      if (ce && m_wait == MAXW) win = 2;
      else if (ve)              win = 1;
      else if (ce)              win = 2;
      else                      win = 0;
      if (ve && ce && m_cnt < 65535) m_cnt++;
      if (!cpu_req || win == 2) m_wait = 0;
      else if (ce)              m_wait = (m_wait + 1 > MAXW) ? MAXW : m_wait + 1;
      m_vrv = m_vack;
      m_crv = m_cack && !m_we;
      if (m_vrv) m_vrd = m_iss;
      if (m_crv) m_crd = m_iss;
      m_vack = (win == 1);
      m_cack = (win == 2);
      m_we   = (win == 2) && cpu_we;
      if (win == 1) begin
        m_addr = vid_addr; m_iss = sh[vid_addr];
      end else if (win == 2) begin
        m_addr = cpu_addr;
        if (cpu_we) begin
          m_wd = cpu_wdata; sh[cpu_addr] = cpu_wdata;
        end else m_iss = sh[cpu_addr];
      end
      tick;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
